boolean_sweep_ctrl: RTL and testbench

BOOLEAN_SWEEP_CTRL -- requirements
Module: boolean_sweep_ctrl

---
 rtl/boolean_pkg.sv | 17 +
 rtl/boolean_sweep_ctrl_settle_timer.sv | 26 ++
 rtl/boolean_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_boolean_sweep_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/boolean_pkg.sv
// Shared types and sizing for the boolean truth-table sweep controller.
// Pure declarations; no logic, no latency, no flow control.
package boolean_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC    = 8;
    localparam int VEC_W      = $clog2(NUM_VEC);
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/boolean_sweep_ctrl_settle_timer.sv
// Settle counter: clears on load, counts while enabled, flags cnt==term.
// Flag is combinational from the count register; no backpressure.
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tc = (r_cnt == term);

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Drives all 8 input vectors of an external 3-input boolean block and captures its truth table.
// Sweep takes 8*(SETTLE_CYC+1) cycles plus one DONE cycle; start ignored while busy, abort cancels.
module boolean_sweep_ctrl
    import boolean_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expect_i,
    input  logic       d_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_o,
    output logic       table_valid,
    output logic       match_o
);

    localparam logic [CNT_W-1:0] TERM    = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] LAST_IX = VEC_W'(NUM_VEC - 1);

    state_t               r_state, w_state_nxt;
    logic [VEC_W-1:0]     r_idx, w_idx_nxt;
    logic [VEC_W-1:0]     r_vec, w_vec_nxt;
    logic [NUM_VEC-1:0]   r_table, w_table_nxt;
    logic                 r_tv, w_tv_nxt;
    logic                 r_match, w_match_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_busy;
    logic                 w_tmr_load, w_tmr_en, w_tmr_tc;

    // Timer restarts on every entry into SETTLE (sweep start or after each sample).
    assign w_tmr_load = ((r_state == ST_IDLE) && start) || (r_state == ST_SAMPLE);
    assign w_tmr_en   = (r_state == ST_SETTLE);

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_tmr_load),
        .en   (w_tmr_en),
        .term (TERM),
        .tc   (w_tmr_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_vec_nxt   = r_vec;
        w_table_nxt = r_table;
        w_tv_nxt    = r_tv;
        w_match_nxt = r_match;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_idx_nxt   = '0;
                    w_vec_nxt   = '0;
                    w_tv_nxt    = 1'b0;
                    w_match_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_tc) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_table_nxt[r_idx] = d_i;
                    if (r_idx == LAST_IX) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_idx_nxt   = r_idx + VEC_W'(1);
                        w_vec_nxt   = r_idx + VEC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_tv_nxt    = 1'b1;
                w_match_nxt = (r_table == expect_i);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_table <= '0;
            r_tv    <= 1'b0;
            r_match <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_vec   <= w_vec_nxt;
            r_table <= w_table_nxt;
            r_tv    <= w_tv_nxt;
            r_match <= w_match_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign a_o         = r_vec[2];
    assign b_o         = r_vec[1];
    assign c_o         = r_vec[0];
    assign busy        = r_busy;
    assign done        = r_done;
    assign table_o     = r_table;
    assign table_valid = r_tv;
    assign match_o     = r_match;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Bench: two controllers (SETTLE_CYC=2 and 1) sweep a table-driven boolean block,
// checked every cycle against a sweep-time model plus literal expectations.
module tb_boolean_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] expect_v;
    logic [7:0] func;

    logic       a0, b0, c0, busy0, done0, tv0, match0, d0;
    logic [7:0] tab0;
    logic       a1, b1, c1, busy1, done1, tv1, match1, d1;
    logic [7:0] tab1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign d0 = func[{a0, b0, c0}];
    assign d1 = func[{a1, b1, c1}];

    boolean_sweep_ctrl #(.SETTLE_CYC(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expect_i(expect_v),
        .d_i(d0), .a_o(a0), .b_o(b0), .c_o(c0), .busy(busy0), .done(done0),
        .table_o(tab0), .table_valid(tv0), .match_o(match0)
    );

    boolean_sweep_ctrl #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expect_i(expect_v),
        .d_i(d1), .a_o(a1), .b_o(b1), .c_o(c1), .busy(busy1), .done(done1),
        .table_o(tab1), .table_valid(tv1), .match_o(match1)
    );

    // Model: a sweep is just elapsed time t since start; vector = t/(S+1),
    // the last cycle of each vector slot samples, t==8*(S+1) is the done cycle.
    logic       m_act[2];
    int         m_t[2];
    logic [2:0] m_abc[2];
    logic [7:0] m_tab[2];
    logic       m_tv[2], m_match[2], m_done[2];

    function automatic int sc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic ab, input logic rs);
        for (int i = 0; i < 2; i++) begin
            int s = sc(i);
            int tt = 8 * (s + 1);
            logic dv = func[m_abc[i]];
            if (rs) begin
                m_act[i] = 0; m_t[i] = 0; m_abc[i] = 0; m_tab[i] = 0;
                m_tv[i] = 0; m_match[i] = 0; m_done[i] = 0;
            end else if (!m_act[i]) begin
                m_done[i] = 0;
                if (st) begin
                    m_act[i] = 1; m_t[i] = 0; m_abc[i] = 0; m_tv[i] = 0; m_match[i] = 0;
                end
            end else if (m_t[i] == tt) begin
                m_done[i] = 0; m_tv[i] = 1; m_match[i] = (m_tab[i] == expect_v); m_act[i] = 0;
            end else begin
                m_done[i] = 0;
                if (ab) begin
                    m_act[i] = 0;
                end else begin
                    if (m_t[i] % (s + 1) == s) m_tab[i][m_t[i] / (s + 1)] = dv;
                    m_t[i]++;
                    if (m_t[i] < tt) m_abc[i] = 3'(m_t[i] / (s + 1));
                    else m_done[i] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("busy0",  {7'd0, busy0}, {7'd0, m_act[0]});
        chk("done0",  {7'd0, done0}, {7'd0, m_done[0]});
        chk("abc0",   {5'd0, a0, b0, c0}, {5'd0, m_abc[0]});
        chk("table0", tab0, m_tab[0]);
        chk("tv0",    {7'd0, tv0}, {7'd0, m_tv[0]});
        chk("match0", {7'd0, match0}, {7'd0, m_match[0]});
        chk("busy1",  {7'd0, busy1}, {7'd0, m_act[1]});
        chk("done1",  {7'd0, done1}, {7'd0, m_done[1]});
        chk("abc1",   {5'd0, a1, b1, c1}, {5'd0, m_abc[1]});
        chk("table1", tab1, m_tab[1]);
        chk("tv1",    {7'd0, tv1}, {7'd0, m_tv[1]});
        chk("match1", {7'd0, match1}, {7'd0, m_match[1]});
    endtask

    // Inputs change at the falling edge; model steps at the rising edge; outputs compared at the next fall.
    task automatic step(input logic st, input logic ab, input logic rs);
        start = st; abort = ab; rst = rs;
        @(posedge clk);
        model_edge(st, ab, rs);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_done(input int which, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            if ((which == 0 && done0) || (which == 1 && done1)) break;
        end
    endtask

    initial begin
        int n;
        int dones;
        func = 8'hEA; expect_v = 8'hEA;
        start = 0; abort = 0; rst = 1;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_abc[i] = 0; m_tab[i] = 0;
            m_tv[i] = 0; m_match[i] = 0; m_done[i] = 0;
        end
        @(negedge clk);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_busy", {7'd0, busy0}, 8'd0);
        chk("rst_table", tab0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        // d=(a&b)|c, matching expectation
        step(1'b1, 1'b0, 1'b0);
        run_until_done(0, 40, n);
        chk("lat_s2", 8'(n), 8'd24);
        chk("tab_ea", tab0, 8'hEA);
        step(1'b0, 1'b0, 1'b0);
        chk("tv_ea", {7'd0, tv0}, 8'd1);
        chk("match_ea", {7'd0, match0}, 8'd1);

        // same block, wrong expectation
        expect_v = 8'hE8;
        step(1'b1, 1'b0, 1'b0);
        run_until_done(0, 40, n);
        step(1'b0, 1'b0, 1'b0);
        chk("tab_e8", tab0, 8'hEA);
        chk("match_e8", {7'd0, match0}, 8'd0);
        expect_v = 8'hEA;
        step(1'b0, 1'b0, 1'b0);
        chk("match_hold", {7'd0, match0}, 8'd0);

        // abort five cycles after start: vector 1 is being driven
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("abort_busy", {7'd0, busy0}, 8'd0);
        chk("abort_tv", {7'd0, tv0}, 8'd0);
        chk("abort_abc", {5'd0, a0, b0, c0}, 8'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // reset while vector 4 is driven, then a clean sweep
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_abc", {5'd0, a0, b0, c0}, 8'd4);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst_busy", {7'd0, busy0}, 8'd0);
        chk("mid_rst_abc", {5'd0, a0, b0, c0}, 8'd0);
        chk("mid_rst_tab", tab0, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        run_until_done(0, 40, n);
        chk("post_rst_tab", tab0, 8'hEA);
        step(1'b0, 1'b0, 1'b0);

        // start held high: two back-to-back sweeps
        dones = 0;
        for (int i = 0; i < 28; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done0) dones++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (done0) dones++;
        end
        chk("held_start_dones", 8'(dones), 8'd2);

        // SETTLE_CYC=1 instance on a^b^c
        func = 8'h96;
        step(1'b1, 1'b0, 1'b0);
        run_until_done(1, 40, n);
        chk("lat_s1", 8'(n), 8'd16);
        chk("tab_96", tab1, 8'h96);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 63) == 0 && !busy0 && !busy1) func = 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                expect_v = ($urandom_range(0, 1) == 1) ? func : 8'($urandom);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
